// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle for ahb_sram_slave; HPROT is present only when AHB_SRAM_PROT_EN is defined.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
`ifdef AHB_SRAM_PROT_EN
  logic [3:0]  HPROT;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, HPROT,
    input  HRDATA, HREADYOUT, HRESP
  );
  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, HPROT,
    output HRDATA, HREADYOUT, HRESP
  );
`else
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
`endif
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite scratch RAM slave: pipelined address/data phases, wait states, two-cycle ERROR.
// Define AHB_SRAM_PROT_EN to block user-mode writes to the upper half of memory via HPROT[1].
module ahb_sram_slave #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned WIN_AW      = 16
) (
  input logic             HCLK,
  input logic             HRESETn,
  ahb_sram_slave_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           hreadyout_q, hreadyout_d;
  logic           hresp_q, hresp_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           pend_q, pend_d;
  logic           write_q, write_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [3:0]     be_q, be_d;

  logic [31:0]    mem_q [DEPTH];

  logic              accept;
  logic [AW-1:0]     a_idx;
  logic [3:0]        a_be;
  logic              a_err;
  logic              a_oor;
  logic [WIN_AW-1:0] win_addr;
  logic              commit;
  logic              rd_load;
  logic [AW-1:0]     rd_idx;
  logic [31:0]       rd_word;

  assign accept   = bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign a_idx    = bus.HADDR[AW+1:2];
  assign win_addr = bus.HADDR[WIN_AW-1:0];
  assign a_oor    = (win_addr >> (AW + 2)) != '0;

  always_comb begin
    a_be = 4'b1111;
    unique case (bus.HSIZE)
      3'd0:    a_be = 4'b0001 << bus.HADDR[1:0];
      3'd1:    a_be = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      default: a_be = 4'b1111;
    endcase
  end

  always_comb begin
    a_err = a_oor || (bus.HSIZE > 3'd2) ||
            ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
            ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
`ifdef AHB_SRAM_PROT_EN
    // User-mode writes may not touch the upper half of the array.
    if (bus.HWRITE && !bus.HPROT[1] && a_idx[AW-1]) a_err = 1'b1;
`endif
  end

  // Only an OKAY transfer in its final (ready) data cycle may write memory.
  assign commit = (state_q == StIdle) && pend_q && write_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    pend_d      = pend_q;
    write_d     = write_q;
    idx_d       = idx_q;
    be_d        = be_q;
    rd_load     = 1'b0;
    rd_idx      = a_idx;
    case (state_q)
      StIdle, StErr2: begin
        state_d     = StIdle;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        pend_d      = 1'b0;
        if (accept) begin
          write_d = bus.HWRITE;
          idx_d   = a_idx;
          be_d    = a_be;
          if (a_err) begin
            state_d     = StErr1;
            hreadyout_d = 1'b0;
            hresp_d     = 1'b1;
          end else begin
            pend_d = 1'b1;
            if (WAIT_STATES != 0) begin
              state_d     = StWait;
              cnt_d       = 4'(WAIT_STATES);
              hreadyout_d = 1'b0;
            end else begin
              rd_load = !bus.HWRITE;
            end
          end
        end
      end
      StWait: begin
        rd_idx = idx_q;
        if (cnt_q == 4'd1) begin
          state_d     = StIdle;
          hreadyout_d = 1'b1;
          rd_load     = !write_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StErr1: begin
        state_d     = StErr2;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b1;
      end
      default: begin
        state_d     = StIdle;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        pend_d      = 1'b0;
      end
    endcase
  end

  // A write committing on the same edge as a read of that word forwards its lanes.
  always_comb begin
    rd_word = mem_q[rd_idx];
    if (commit && (idx_q == rd_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) rd_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
      end
    end
    rdata_d = rd_load ? rd_word : rdata_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      rdata_q     <= 32'd0;
      pend_q      <= 1'b0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      be_q        <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      rdata_q     <= rdata_d;
      pend_q      <= pend_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      be_q        <= be_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[idx_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  assign bus.HRDATA    = rdata_q;
  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;

  logic unused_bits;
`ifdef AHB_SRAM_PROT_EN
  assign unused_bits = ^{bus.HADDR[31:WIN_AW], bus.HTRANS[0], bus.HPROT[3:2], bus.HPROT[0]};
`else
  assign unused_bits = ^{bus.HADDR[31:WIN_AW], bus.HTRANS[0]};
`endif

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite slave backed by an internal word-addressed flop memory. Successor to the single-cycle 16-word slave.
- Adds parametrised depth and wait states, true address/data-phase pipelining, HTRANS qualification, and byte/halfword writes via HSIZE.
- Adds a two-cycle ERROR response for bad addresses or sizes.
- Sits behind the AHB decoder/mux as a generic scratch RAM.

Parameters:
- DEPTH, 16, number of 32-bit words; power of 2, 2..1024.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase; 0..15.
- WIN_AW, 16, byte-address width of the decoded window. HADDR[WIN_AW-1:log2(DEPTH)+2] nonzero = out of range.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset; asynchronous assert, active-low
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HTRANS  in  2  transfer type (IDLE/BUSY/NONSEQ/SEQ)
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 byte, 1 half, 2 word
- HWDATA  in  32  write data, valid in data phase
- HREADY  in  1  bus ready (mux output)
- HRDATA  out  32  read data, registered
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 OKAY, 1 ERROR

Behaviour:
- Reset values: HRDATA=0, HREADYOUT=1, HRESP=0, FSM=IDLE. Pending transfer dropped. Memory contents not reset.
- Address phase accepted at a rising edge with HSEL && HREADY && HTRANS[1]. Latch addr, write, size, and error flag.
- IDLE/BUSY or !HSEL gives a zero-wait OKAY data phase with no access.
- Error conditions:
  - out of range (per WIN_AW);
  - HSIZE>2;
  - misaligned: half with HADDR[0]=1, word with HADDR[1:0]!=0.
- FSM states and transitions:
  - IDLE: data phase free or OKAY-complete. Accepted OK transfer goes to WAIT if WAIT_STATES>0, else stays in DATA-final behaviour. Accepted error transfer goes to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0; counter loads WAIT_STATES and decrements. On last wait cycle, next cycle is the final data cycle with HREADYOUT=1.
  - ERR1: HREADYOUT=0, HRESP=1. Next state ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. New address phase may be accepted at this edge.
- Write commit:
  - Memory written at the edge ending the final data cycle (HREADYOUT=1), using HWDATA then.
  - Byte lanes: byte uses lane HADDR[1:0]; half uses lanes {HADDR[1],0}+1..0; word uses all lanes.
  - Errored writes never modify memory.
- Read data:
  - HRDATA loaded at the edge entering the final data cycle. For WAIT_STATES=0 this is the address-phase edge.
  - HRDATA is valid while HREADYOUT=1. HRDATA holds at all other times; errored reads leave HRDATA unchanged.
- Write-to-read forwarding (back-to-back, WAIT_STATES=0): if a write commits at the same edge a read of the same word loads HRDATA, written lanes are forwarded from HWDATA and unwritten lanes come from memory.
- Reads always return the full word; the master selects lanes.
- While HREADYOUT=0, address-phase signals are ignored because HREADY is low.
- Reset asserted mid-WAIT or mid-ERR: immediate return to reset values; the in-flight write is not committed.

Optional Feature:
- Macro AHB_SRAM_PROT_EN.
- Defined: adds input HPROT[3:0]. Writes with HPROT[1]=0 (user access) to the upper half of memory (word index >= DEPTH/2) get the ERROR response, and memory is unchanged. Reads are unaffected.
- Undefined: no HPROT port; all in-range aligned writes permitted.

Test Plan:
- Reset then idle, WAIT_STATES=0, DEPTH=16 -> HRDATA=0, HREADYOUT=1, HRESP=0. HTRANS=IDLE with HSEL=1 gives OKAY and no memory change.
- Word write 0xDEADBEEF to 0x08, then immediate back-to-back read of 0x08 -> forwarded HRDATA=0xDEADBEEF in the read data phase, zero waits.
- Word write 0x11223344 to 0x04; byte write 0xAA.. on lane 2 (HADDR=0x06, HSIZE=0); half write 0x5566 to 0x04 -> read 0x04 returns 0x11AA5566.
- WAIT_STATES=3, read of 0x0C -> HREADYOUT low for exactly 3 cycles, then high with HRDATA = stored word.
- Read of 0x40 (out of range, DEPTH=16) and word write to 0x02 (misaligned) -> each gets ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1). HRDATA is unchanged and word 0 is unchanged.
- HRESETn pulsed low during cycle 2 of a 3-wait write -> outputs return to reset values at once; a subsequent read shows the old data.
